tile_transpose_buf: RTL and testbench
=====================================

// Module: tile_transpose_buf
// PURPOSE
//  Ping-pong DIM_p x DIM_p tile buffer between operand memory and the torus systolic array.
//  Accepts one full row per cycle and emits one re-ordered vector per cycle: identity, transpose, or rotate.
//  Two banks let the load of tile N+1 overlap the drain of tile N (sustained 1 vector/cycle).
// PARAMETERS
//  DIM_p    8  matrix dimension (>=2)
//  WIDTH_p  8  element width in bits
// PORTS
//  clk_i        in   1              single clock, all state on posedge
//  rst_i        in   1              synchronous, active-high reset
//  op_i         in   2              op[1]=transpose, op[0]=rotate; sampled with first row of a tile
//  valid_i      in   1              row_i valid
//  ready_o      out  1              buffer can accept a row
//  row_i        in   DIM_p*WIDTH_p  input row; element j at [j*WIDTH_p +: WIDTH_p]
//  flush_i      in   1              discard all stored/partial tiles
//  out_valid_o  out  1              out_data_o valid
//  out_ready_i  in   1              consumer accepts out_data_o
//  out_data_o   out  DIM_p*WIDTH_p  output vector k; element j at [j*WIDTH_p +: WIDTH_p]
//  out_idx_o    out  $clog2(DIM_p)  index k of current output vector
//  out_last_o   out  1              k == DIM_p-1
//  full_o       out  1              both banks hold unread/partly-read tiles
// BEHAVIOUR
//  - Reset/flush: both banks EMPTY, wr/rd bank ptr=0, row/out counters=0; ready_o=1, out_valid_o=0,
//    out_idx_o=0, out_last_o=0, full_o=0, out_data_o=0. Partial tiles are discarded, never emitted.
//  - Bank states: EMPTY -> FILLING (first row accepted) -> FULL (row DIM_p-1 accepted)
//    -> DRAINING (first vector accepted) -> EMPTY (vector DIM_p-1 accepted). FULL->EMPTY directly if DIM_p==1 n/a.
//  - Row accepted on valid_i&&ready_o; ready_o=1 iff write bank is EMPTY or FILLING. On last row: the wr ptr toggles
//    and op is latched into that bank's op register.
//  - out_valid_o=1 iff read bank is FULL or DRAINING; vector accepted on out_valid_o&&out_ready_i; on last vector the
//    rd ptr toggles. out_data_o holds stable while out_valid_o&&!out_ready_i.
//  - Latency: last row accepted in cycle t -> out_valid_o=1 in cycle t+1 (bank empty case). No bubbles between
//    back-to-back tiles when out_ready_i=1.
//  - Mapping (M = stored tile, out[k][j] = element j of vector k):
//    00 identity  out[k][j]=M[k][j];   10 transpose  out[k][j]=M[j][k]
//    01 rot90 cw  out[k][j]=M[DIM_p-1-j][k];   11 rot90 ccw  out[k][j]=M[j][DIM_p-1-k]
//  - Simultaneous last-row write to one bank and last-vector read of the other: both transitions occur in the
//    same cycle. Writes and reads never touch the same bank in a cycle.
//  - full_o=1 iff neither bank is EMPTY or FILLING (ready_o==!full_o).
//  - flush_i has priority over valid_i/out_ready_i in the same cycle; rst_i has priority over flush_i.
//  - Data is moved, never arithmetically modified; no width change.
// CONFIGURATION
//  TILE_TRANSPOSE_BUF_ROTATE_EN: defined -> op[0] honoured (rot90 cw/ccw modes available).
//  Undefined -> op[0] ignored, treated as 0 (modes 01->00, 11->10); rotate index muxes not built.
// STRUCTURE
//  Package tile_transpose_pkg: op_e enum (OP_IDENT, OP_ROT_CW, OP_TRANS, OP_ROT_CCW), bank_state_e enum
//  (EMPTY, FILLING, FULL, DRAINING), helper function for index mapping.
//  Sub-module tile_transpose_bank (instantiated x2): DIM_p x DIM_p register array, row write port,
//  op-mapped vector read port (combinational on k). Top holds state FSMs, pointers, counters, handshakes.
// TESTING (DIM_p=4, WIDTH_p=8, M[r][c]=8'h{r}{c}, e.g. M[2][1]=8'h21)
//  1 op=00, 4 rows, out_ready=1 -> out_valid next cycle, vector0={00,01,02,03} (elem0 first), out_last on k=3.
//  2 op=10 -> vector1={01,11,21,31}; out_valid exactly 1 cycle after 4th row accepted.
//  3 op=01 (ROTATE_EN) -> vector0={30,20,10,00}; without macro same stimulus yields {00,01,02,03}.
//  4 two tiles back-to-back (op 00 then 10), out_ready=1 -> ready_o never drops, 8 contiguous outputs, 2nd tile transposed.
//  5 out_ready=0, feed 9 rows -> after 8 rows full_o=1, ready_o=0, 9th row stalls; release -> 8 vectors then stalled row loads.
//  6 rst_i (and separately flush_i) after 2 rows -> out_valid stays 0; next 4 rows produce a clean tile matching mapping.

Source files
------------

// File: rtl/tile_transpose_pkg.sv
// Shared types and the output index mapping for the ping-pong tile transpose buffer.
package tile_transpose_pkg;

    typedef enum logic [1:0] {
        OP_IDENT   = 2'b00,
        OP_ROT_CW  = 2'b01,
        OP_TRANS   = 2'b10,
        OP_ROT_CCW = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_e;

    // Flat storage index (row*dim+col) of the element that lands at out[k][j].
    function automatic int unsigned map_idx(input op_e op, input int unsigned k,
                                            input int unsigned j, input int unsigned dim);
        int unsigned row;
        int unsigned col;
        case (op)
            OP_TRANS: begin
                row = j;
                col = k;
            end
            OP_ROT_CW: begin
                row = dim - 1 - j;
                col = k;
            end
            OP_ROT_CCW: begin
                row = j;
                col = dim - 1 - k;
            end
            default: begin
                row = k;
                col = j;
            end
        endcase
        return row * dim + col;
    endfunction

endpackage

// File: rtl/tile_transpose_bank.sv
// One DIM_p x DIM_p tile store: full-row write port and an op-mapped combinational vector read.
module tile_transpose_bank
    import tile_transpose_pkg::*;
#(
    parameter int unsigned DIM_p   = 8,
    parameter int unsigned WIDTH_p = 8
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DIM_p)-1:0]   wr_row_i,
    input  logic [DIM_p*WIDTH_p-1:0]   row_i,
    input  logic                       op_we_i,
    input  op_e                        op_i,
    input  logic [$clog2(DIM_p)-1:0]   rd_idx_i,
    output logic [DIM_p*WIDTH_p-1:0]   rd_data_o
);

    localparam int unsigned AW = $clog2(DIM_p * DIM_p);

    logic [WIDTH_p-1:0] r_mem [DIM_p*DIM_p];
    op_e                r_op;

    // Payload only; bank validity is tracked in the top, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int j = 0; j < DIM_p; j++) begin
                r_mem[AW'(32'(wr_row_i) * DIM_p + 32'(j))] <= row_i[j*WIDTH_p +: WIDTH_p];
            end
        end
        if (op_we_i) begin
            r_op <= op_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int j = 0; j < DIM_p; j++) begin
            rd_data_o[j*WIDTH_p +: WIDTH_p] = r_mem[AW'(map_idx(r_op, 32'(rd_idx_i), j, DIM_p))];
        end
    end

endmodule

// File: rtl/tile_transpose_buf.sv
// Ping-pong tile buffer feeding the systolic array: row in, re-ordered vector out, 1/cycle each.
// TILE_TRANSPOSE_BUF_ROTATE_EN enables the rot90 modes; otherwise op_i[0] is ignored.
module tile_transpose_buf
    import tile_transpose_pkg::*;
#(
    parameter int unsigned DIM_p   = 8,
    parameter int unsigned WIDTH_p = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 op_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DIM_p*WIDTH_p-1:0]   row_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DIM_p*WIDTH_p-1:0]   out_data_o,
    output logic [$clog2(DIM_p)-1:0]   out_idx_o,
    output logic                       out_last_o,
    output logic                       full_o
);

    localparam int unsigned CW = $clog2(DIM_p);
    localparam logic [CW-1:0] LastIdx = CW'(DIM_p - 1);

    bank_state_e r_state [2];
    bank_state_e w_state_nxt [2];
    logic        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_row_cnt, r_out_cnt;
    op_e         r_op_pend, w_op_in;
    logic        w_wr_open, w_rd_avail, w_wr_fire, w_rd_fire, w_wr_last, w_rd_last;
    logic [DIM_p*WIDTH_p-1:0] w_bank_data [2];

`ifdef TILE_TRANSPOSE_BUF_ROTATE_EN
    assign w_op_in = op_e'(op_i);
`else
    logic w_unused_op;
    assign w_op_in     = op_e'({op_i[1], 1'b0});
    assign w_unused_op = op_i[0];
`endif

    assign w_wr_open  = (r_state[r_wr_ptr] == EMPTY) || (r_state[r_wr_ptr] == FILLING);
    assign w_rd_avail = (r_state[r_rd_ptr] == FULL) || (r_state[r_rd_ptr] == DRAINING);
    assign w_wr_fire  = valid_i && w_wr_open;
    assign w_rd_fire  = out_ready_i && w_rd_avail;
    assign w_wr_last  = w_wr_fire && (r_row_cnt == LastIdx);
    assign w_rd_last  = w_rd_fire && (r_out_cnt == LastIdx);

    // Write bank is always EMPTY/FILLING and read bank FULL/DRAINING, so they never collide.
    always_comb begin
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        if (w_wr_fire) begin
            w_state_nxt[r_wr_ptr] = w_wr_last ? FULL : FILLING;
        end
        if (w_rd_fire) begin
            w_state_nxt[r_rd_ptr] = w_rd_last ? EMPTY : DRAINING;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state[0] <= EMPTY;
            r_state[1] <= EMPTY;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_row_cnt  <= '0;
            r_out_cnt  <= '0;
            r_op_pend  <= OP_IDENT;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            if (w_wr_fire) begin
                r_row_cnt <= w_wr_last ? '0 : r_row_cnt + CW'(1);
                if (r_row_cnt == '0) begin
                    r_op_pend <= w_op_in;
                end
                if (w_wr_last) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
            end
            if (w_rd_fire) begin
                r_out_cnt <= w_rd_last ? '0 : r_out_cnt + CW'(1);
                if (w_rd_last) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tile_transpose_bank #(
            .DIM_p   (DIM_p),
            .WIDTH_p (WIDTH_p)
        ) u_bank (
            .clk_i     (clk_i),
            .we_i      (w_wr_fire && (r_wr_ptr == 1'(b))),
            .wr_row_i  (r_row_cnt),
            .row_i     (row_i),
            .op_we_i   (w_wr_last && (r_wr_ptr == 1'(b))),
            .op_i      (r_op_pend),
            .rd_idx_i  (r_out_cnt),
            .rd_data_o (w_bank_data[b])
        );
    end

    assign ready_o     = w_wr_open;
    assign full_o      = !w_wr_open;
    assign out_valid_o = w_rd_avail;
    assign out_idx_o   = r_out_cnt;
    assign out_last_o  = w_rd_avail && (r_out_cnt == LastIdx);
    assign out_data_o  = w_rd_avail ? w_bank_data[r_rd_ptr] : '0;

endmodule

// File: tb/tb_tile_transpose_buf.sv
// Scoreboard bench for tile_transpose_buf at DIM_p=4, WIDTH_p=8; honours TILE_TRANSPOSE_BUF_ROTATE_EN.
module tb_tile_transpose_buf;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_i;
    logic [1:0]  op_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] row_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [1:0]  out_idx_o;
    logic        out_last_o;
    logic        full_o;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    int   stall_cnt = 0;

    tile_transpose_buf #(
        .DIM_p   (4),
        .WIDTH_p (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .op_i        (op_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .row_i       (row_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_idx_o   (out_idx_o),
        .out_last_o  (out_last_o),
        .full_o      (full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkrow(input logic [7:0] base, input int r);
        logic [31:0] v;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = base + 8'(r * 16 + c);
        return v;
    endfunction

    // Reference: out[k][j] = M[r][c] with M[r][c] = base + 0x{r}{c}.
    function automatic logic [31:0] model_vec(input logic [7:0] base, input logic [1:0] op,
                                              input int k);
        logic [31:0] v;
        logic [1:0]  eop;
        int r, c;
        eop = op;
`ifndef TILE_TRANSPOSE_BUF_ROTATE_EN
        eop[0] = 1'b0;
`endif
        for (int j = 0; j < 4; j++) begin
            case (eop)
                2'b00:   begin r = k;     c = j;     end
                2'b10:   begin r = j;     c = k;     end
                2'b01:   begin r = 3 - j; c = k;     end
                default: begin r = j;     c = 3 - k; end
            endcase
            v[j*8 +: 8] = base + 8'(r * 16 + c);
        end
        return v;
    endfunction

    task automatic push_tile(input logic [7:0] base, input logic [1:0] op);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.data = model_vec(base, op, k);
            e.idx  = 2'(k);
            e.last = (k == 3);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the row is taken.
    task automatic send_row(input logic [31:0] row, input logic [1:0] op);
        logic acc;
        int   guard;
        valid_i = 1'b1;
        row_i   = row;
        op_i    = op;
        guard   = 0;
        do begin
            acc = ready_o;
            @(posedge clk);
            #1;
            if (!acc) stall_cnt++;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL row_accept: got timeout, expected row accepted");
        end
        valid_i = 1'b0;
    endtask

    task automatic send_tile(input logic [7:0] base, input logic [1:0] op);
        for (int r = 0; r < 4; r++) send_row(mkrow(base, r), op);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            step(1);
            guard++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        check({name, "_idle"}, 32'(out_valid_o), 32'd0);
    endtask

    always @(negedge clk) begin
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_vec", out_data_o, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_pop++;
                check("sb_data", out_data_o, e.data);
                check("sb_idx", 32'(out_idx_o), 32'(e.idx));
                check("sb_last", 32'(out_last_o), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; op_i = 2'b00; row_i = '0;
        out_ready_i = 1'b0;
        step(2);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_idx", 32'(out_idx_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_data", out_data_o, 32'd0);
        rst_i = 1'b0;
        out_ready_i = 1'b1;

        // Identity, first vector visible the cycle after the last row.
        push_tile(8'h00, 2'b00);
        send_tile(8'h00, 2'b00);
        check("t1_valid", 32'(out_valid_o), 32'd1);
        check("t1_vec0", out_data_o, 32'h0302_0100);
        check("t1_idx0", 32'(out_idx_o), 32'd0);
        wait_drain("t1");

        // Transpose with exact one-cycle latency.
        push_tile(8'h00, 2'b10);
        for (int r = 0; r < 3; r++) send_row(mkrow(8'h00, r), 2'b10);
        check("t2_pre_valid", 32'(out_valid_o), 32'd0);
        send_row(mkrow(8'h00, 3), 2'b10);
        check("t2_valid", 32'(out_valid_o), 32'd1);
        step(1);
        check("t2_idx1", 32'(out_idx_o), 32'd1);
        check("t2_vec1", out_data_o, 32'h3121_1101);
        wait_drain("t2");

        // Rotate cw (falls back to identity without the rotate build).
        push_tile(8'h00, 2'b01);
        send_tile(8'h00, 2'b01);
`ifdef TILE_TRANSPOSE_BUF_ROTATE_EN
        check("t3_vec0", out_data_o, 32'h0010_2030);
`else
        check("t3_vec0", out_data_o, 32'h0302_0100);
`endif
        wait_drain("t3");

        // Back-to-back tiles: no input stall, 8 contiguous vectors.
        stall_cnt = 0;
        push_tile(8'h00, 2'b00);
        push_tile(8'h40, 2'b10);
        p0 = n_pop;
        send_tile(8'h00, 2'b00);
        send_tile(8'h40, 2'b10);
        check("t4_no_stall", 32'(stall_cnt), 32'd0);
        check("t4_popped_a", 32'(n_pop - p0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t4_contig", 32'(out_valid_o), 32'd1);
            check("t4_idx", 32'(out_idx_o), 32'(i));
            step(1);
        end
        check("t4_popped_all", 32'(n_pop - p0), 32'd8);
        wait_drain("t4");

        // Back-pressure: two tiles fill both banks, ninth row stalls until a bank frees.
        out_ready_i = 1'b0;
        push_tile(8'h00, 2'b00);
        push_tile(8'h40, 2'b01);
        push_tile(8'h80, 2'b10);
        send_tile(8'h00, 2'b00);
        send_tile(8'h40, 2'b01);
        check("t5_full", 32'(full_o), 32'd1);
        check("t5_ready", 32'(ready_o), 32'd0);
        valid_i = 1'b1;
        row_i   = mkrow(8'h80, 0);
        op_i    = 2'b10;
        step(3);
        check("t5_stall_ready", 32'(ready_o), 32'd0);
        check("t5_stall_hold", out_data_o, 32'h0302_0100);
        check("t5_stall_idx", 32'(out_idx_o), 32'd0);
        out_ready_i = 1'b1;
        send_row(mkrow(8'h80, 0), 2'b10);
        for (int r = 1; r < 4; r++) send_row(mkrow(8'h80, r), 2'b10);
        wait_drain("t5");

        // Reset after a partial tile, then a clean tile.
        send_row(mkrow(8'h20, 0), 2'b00);
        send_row(mkrow(8'h20, 1), 2'b00);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_rst_novalid", 32'(out_valid_o), 32'd0);
            step(1);
        end
        push_tile(8'h00, 2'b10);
        send_tile(8'h00, 2'b10);
        wait_drain("t6r");

        // Flush beats a simultaneous row write.
        send_row(mkrow(8'h20, 0), 2'b00);
        send_row(mkrow(8'h20, 1), 2'b00);
        flush_i = 1'b1;
        valid_i = 1'b1;
        row_i   = mkrow(8'h20, 2);
        step(1);
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("t6_flush_ready", 32'(ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t6_flush_novalid", 32'(out_valid_o), 32'd0);
            step(1);
        end
        push_tile(8'hC0, 2'b11);
        send_tile(8'hC0, 2'b11);
        wait_drain("t6f");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
